// File: rtl/sram_pkg.sv
// Shared constants, decode result type and the address decode helper for the
// banked SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_WORD_W = 32;
  localparam int unsigned SRAM_BE_W   = 4;

  typedef struct packed {
    logic        legal;
    logic [3:0]  bank;
    logic [15:0] word;
  } sram_dec_t;

  // Range check plus bank/word split. Alignment and write legality are
  // port-specific and are checked by the caller.
  function automatic sram_dec_t sram_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned nbanks,
                                            input int unsigned aw);
    sram_dec_t   dec;
    logic [31:0] off;
    logic [63:0] window;
    off       = addr - base;
    window    = 64'(nbanks) << (aw + 2);
    dec.legal = (addr >= base) && ({32'd0, off} < window);
    dec.bank  = 4'(off >> (aw + 2));
    dec.word  = 16'((off >> 2) & ((32'd1 << aw) - 32'd1));
    return dec;
  endfunction

endpackage

// File: rtl/sram_banked_ctrl_if.sv
// OBI-style request/response bundle used for both the data and instruction
// ports of the banked SRAM controller.
interface sram_banked_ctrl_if;
  import sram_pkg::*;

  logic                   req;
  logic                   gnt;
  logic [31:0]            addr;
  logic                   we;
  logic [SRAM_BE_W-1:0]   be;
  logic [SRAM_WORD_W-1:0] wdata;
  logic                   rvalid;
  logic [SRAM_WORD_W-1:0] rdata;
  logic                   err;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/sram_banked_ctrl_macro.sv
// Behavioural stand-in for one sky130 1rw1r 32x512 macro: port 0 read/write
// with byte mask, port 1 read-only, both with registered dout, chip selects active-low.
module sram_banked_ctrl_macro
  import sram_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic                   clk_i,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [SRAM_BE_W-1:0]   wmask0,
  input  logic [AW-1:0]          addr0,
  input  logic [SRAM_WORD_W-1:0] din0,
  output logic [SRAM_WORD_W-1:0] dout0,
  input  logic                   csb1,
  input  logic [AW-1:0]          addr1,
  output logic [SRAM_WORD_W-1:0] dout1
);

  logic [SRAM_WORD_W-1:0] mem [2**AW];

  // NOTE: storage arrays and dout carry no reset; a reset loop would turn the
  // array into flops. Consumers qualify dout with their own valid flags.
  always_ff @(posedge clk_i) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < int'(SRAM_BE_W); i++) begin
          if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

// File: rtl/sram_resp_pipe.sv
// Per-port response path: registers bank select, error and write flags at
// grant, muxes macro dout next cycle, with an optional extra output stage.
module sram_resp_pipe
  import sram_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 6,
  parameter int unsigned BANK_SEL_W = 3,
  parameter int unsigned RDATA_REG  = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  fire,
  input  logic                                  is_err,
  input  logic                                  is_write,
  input  logic [BANK_SEL_W-1:0]                 bank_sel,
  input  logic [NUM_BANKS-1:0][SRAM_WORD_W-1:0] dout,
  output logic                                  rvalid,
  output logic [SRAM_WORD_W-1:0]                rdata,
  output logic                                  err
);

  logic                   v_q, err_q, we_q;
  logic [BANK_SEL_W-1:0]  sel_q;
  logic                   rvalid_c, err_c;
  logic [SRAM_WORD_W-1:0] rdata_c;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= 1'b0;
      err_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      v_q <= fire;
      if (fire) begin
        err_q <= is_err;
        we_q  <= is_write;
        sel_q <= bank_sel;
      end
    end
  end

  // Errors and writes return zero data; only legal reads expose dout.
  assign rvalid_c = v_q;
  assign err_c    = v_q && err_q;
  assign rdata_c  = (v_q && !err_q && !we_q) ? dout[sel_q] : '0;

  if (RDATA_REG != 0) begin : g_out_reg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rvalid <= 1'b0;
        err    <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= rvalid_c;
        err    <= err_c;
        rdata  <= rdata_c;
      end
    end
  end else begin : g_out_comb
    assign rvalid = rvalid_c;
    assign err    = err_c;
    assign rdata  = rdata_c;
  end

endmodule

// File: rtl/sram_banked_ctrl.sv
// Banked SRAM controller: data (rw) and instruction (r) ports over NUM_BANKS
// 1rw1r macros. Define SRAM_ERR_CAPTURE_EN to add fault address/count capture.
module sram_banked_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned NUM_BANKS = 6,
  parameter int unsigned BANK_AW   = 9,
  parameter int unsigned RDATA_REG = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sram_banked_ctrl_if.slave  d_bus,
  sram_banked_ctrl_if.slave  i_bus,
  output logic               illegal_memory_o
`ifdef SRAM_ERR_CAPTURE_EN
  ,
  input  logic               err_clr_i,
  output logic [31:0]        err_addr_o,
  output logic [7:0]         err_cnt_o
`endif
);

  localparam int unsigned BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  sram_dec_t d_dec, i_dec;
  logic      d_ok, i_ok, hazard;
  logic      d_fire, i_fire, d_fault, i_fault;
  logic [NUM_BANKS-1:0]                  d_csb_n, i_csb_n;
  logic [NUM_BANKS-1:0][SRAM_WORD_W-1:0] dout0, dout1;
  logic      unused_bits;

  assign d_dec = sram_decode(d_bus.addr, BASE_ADDR, NUM_BANKS, BANK_AW);
  assign i_dec = sram_decode(i_bus.addr, BASE_ADDR, NUM_BANKS, BANK_AW);
  assign d_ok  = d_dec.legal && (d_bus.addr[1:0] == 2'b00);
  assign i_ok  = i_dec.legal && (i_bus.addr[1:0] == 2'b00) && !i_bus.we;

  // A write and a read of the same word never reach a macro together; the
  // instruction side backs off and retries.
  assign hazard = d_bus.req && d_ok && d_bus.we && i_bus.req && i_ok &&
                  (d_dec.bank == i_dec.bank) && (d_dec.word == i_dec.word);

  assign d_bus.gnt = d_bus.req;
  assign i_bus.gnt = i_bus.req && !hazard;
  assign d_fire    = d_bus.req;
  assign i_fire    = i_bus.req && !hazard;
  assign d_fault   = d_fire && !d_ok;
  assign i_fault   = i_fire && !i_ok;
  assign illegal_memory_o = d_fault || i_fault;

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    assign d_csb_n[b] = !(d_fire && d_ok && (d_dec.bank == 4'(b)));
    assign i_csb_n[b] = !(i_fire && i_ok && (i_dec.bank == 4'(b)));

    sram_banked_ctrl_macro #(.AW(BANK_AW)) u_macro (
      .clk_i  (clk_i),
      .csb0   (d_csb_n[b]),
      .web0   (!d_bus.we),
      .wmask0 (d_bus.be),
      .addr0  (d_dec.word[BANK_AW-1:0]),
      .din0   (d_bus.wdata),
      .dout0  (dout0[b]),
      .csb1   (i_csb_n[b]),
      .addr1  (i_dec.word[BANK_AW-1:0]),
      .dout1  (dout1[b])
    );
  end

  sram_resp_pipe #(.NUM_BANKS(NUM_BANKS), .BANK_SEL_W(BANK_SEL_W), .RDATA_REG(RDATA_REG)) u_d_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fire     (d_fire),
    .is_err   (!d_ok),
    .is_write (d_bus.we),
    .bank_sel (d_dec.bank[BANK_SEL_W-1:0]),
    .dout     (dout0),
    .rvalid   (d_bus.rvalid),
    .rdata    (d_bus.rdata),
    .err      (d_bus.err)
  );

  sram_resp_pipe #(.NUM_BANKS(NUM_BANKS), .BANK_SEL_W(BANK_SEL_W), .RDATA_REG(RDATA_REG)) u_i_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fire     (i_fire),
    .is_err   (!i_ok),
    .is_write (1'b0),
    .bank_sel (i_dec.bank[BANK_SEL_W-1:0]),
    .dout     (dout1),
    .rvalid   (i_bus.rvalid),
    .rdata    (i_bus.rdata),
    .err      (i_bus.err)
  );

  assign unused_bits = ^{d_dec, i_dec, i_bus.be, i_bus.wdata};

`ifdef SRAM_ERR_CAPTURE_EN
  logic       err_seen;
  logic [8:0] cnt_sum;

  assign cnt_sum = {1'b0, err_cnt_o} + 9'(d_fault) + 9'(i_fault);

  // Clear wins over a same-cycle fault; the data port wins the address slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || err_clr_i) begin
      err_seen   <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else if (d_fault || i_fault) begin
      if (!err_seen) begin
        err_seen   <= 1'b1;
        err_addr_o <= d_fault ? d_bus.addr : i_bus.addr;
      end
      err_cnt_o <= (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
    end
  end
`else
  // Capture disabled: no fault registers exist in this build.
`endif

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Scoreboard bench for sram_banked_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them including response latency.
module tb_sram_banked_ctrl;
  import sram_pkg::*;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned NB        = 6;
  localparam int unsigned RDATA_REG = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic illegal;
`ifdef SRAM_ERR_CAPTURE_EN
  logic        err_clr = 1'b0;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t d_q[$];
  exp_t i_q[$];
  exp_t d_e, i_e;
  logic exp_i_gnt = 1'b0;
  logic exp_ill   = 1'b0;

  sram_banked_ctrl_if d_bus ();
  sram_banked_ctrl_if i_bus ();

  sram_banked_ctrl #(.BASE_ADDR(BASE), .NUM_BANKS(NB), .BANK_AW(9), .RDATA_REG(RDATA_REG)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .d_bus            (d_bus),
    .i_bus            (i_bus),
    .illegal_memory_o (illegal)
`ifdef SRAM_ERR_CAPTURE_EN
    ,
    .err_clr_i        (err_clr),
    .err_addr_o       (err_addr),
    .err_cnt_o        (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_bus();
    d_bus.req = 1'b0; d_bus.addr = '0; d_bus.we = 1'b0; d_bus.be = '0; d_bus.wdata = '0;
    i_bus.req = 1'b0; i_bus.addr = '0; i_bus.we = 1'b0; i_bus.be = '0; i_bus.wdata = '0;
    exp_ill   = 1'b0;
    exp_i_gnt = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    d_bus.req = 1'b1; d_bus.addr = a; d_bus.we = we; d_bus.be = be; d_bus.wdata = wd;
    d_q.push_back('{exp_rd, exp_err, cyc + 1 + int'(RDATA_REG)});
    exp_ill = exp_ill | exp_err;
  endtask

  task automatic issue_i(input logic [31:0] a, input logic we, input logic gnt,
                         input logic [31:0] exp_rd, input logic exp_err);
    i_bus.req = 1'b1; i_bus.addr = a; i_bus.we = we;
    exp_i_gnt = gnt;
    if (gnt) begin
      i_q.push_back('{exp_rd, exp_err, cyc + 1 + int'(RDATA_REG)});
      exp_ill = exp_ill | exp_err;
    end
  endtask

  // Checks grant-cycle outputs, then advances exactly one clock.
  task automatic step();
    #1;
    check("illegal_memory", 32'(illegal), 32'(exp_ill));
    if (d_bus.req) check("d_gnt", 32'(d_bus.gnt), 32'd1);
    if (i_bus.req) check("i_gnt", 32'(i_bus.gnt), 32'(exp_i_gnt));
    @(posedge clk);
    #1;
    clear_bus();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (d_bus.rvalid) begin
        if (d_q.size() == 0) check("d_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          d_e = d_q.pop_front();
          check("d_rdata", d_bus.rdata, d_e.rdata);
          check("d_err", 32'(d_bus.err), 32'(d_e.err));
          check("d_latency_cycle", 32'(cyc), 32'(d_e.at));
        end
      end
      if (i_bus.rvalid) begin
        if (i_q.size() == 0) check("i_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          i_e = i_q.pop_front();
          check("i_rdata", i_bus.rdata, i_e.rdata);
          check("i_err", 32'(i_bus.err), 32'(i_e.err));
          check("i_latency_cycle", 32'(cyc), 32'(i_e.at));
        end
      end
    end
  end

  initial begin
    clear_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_rvalid", 32'(d_bus.rvalid), 32'd0);
    check("rst_i_rvalid", 32'(i_bus.rvalid), 32'd0);
    check("rst_d_rdata", d_bus.rdata, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
`ifdef SRAM_ERR_CAPTURE_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Preload, then legal read of bank 1 word 1
    issue_d(BASE + 32'h804, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0); step();
    issue_d(BASE + 32'h020, 1'b1, 4'hF, 32'h1122_3344, 32'h0, 1'b0); step();
    issue_d(BASE + 32'h804, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
    #1;
    check("d_csb_bank1", 32'(dut.d_csb_n), 32'(6'b111101));
    step();

    // Illegal accesses: out of range, misaligned, below base, instruction write
    issue_i(BASE + NB * 32'h800, 1'b0, 1'b1, 32'h0, 1'b1);
    #1;
    check("i_csb_none", 32'(dut.i_csb_n), 32'(6'b111111));
    step();
    issue_d(BASE + 32'h2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1); step();
    issue_d(32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1); step();
    issue_i(BASE + 32'h20, 1'b1, 1'b1, 32'h0, 1'b1); step();

    // Last word of the window is legal
    issue_d(BASE + 32'h2FFC, 1'b1, 4'hF, 32'h5A5A_0001, 32'h0, 1'b0); step();
    issue_i(BASE + 32'h2FFC, 1'b0, 1'b1, 32'h5A5A_0001, 1'b0); step();

    // Same-word write/read hazard, then retry
    issue_d(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue_i(BASE + 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    issue_i(BASE + 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0); step();

    // Byte lane write, be=0 no-op, same-word dual read, different-word write+read
    issue_d(BASE + 32'h20, 1'b1, 4'b0100, 32'h00AB_0000, 32'h0, 1'b0); step();
    issue_d(BASE + 32'h20, 1'b0, 4'hF, 32'h0, 32'h11AB_3344, 1'b0); step();
    issue_d(BASE + 32'h20, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0); step();
    issue_d(BASE + 32'h20, 1'b0, 4'hF, 32'h0, 32'h11AB_3344, 1'b0);
    issue_i(BASE + 32'h20, 1'b0, 1'b1, 32'h11AB_3344, 1'b0);
    step();
    issue_d(BASE + 32'h24, 1'b1, 4'hF, 32'h0000_0077, 32'h0, 1'b0);
    issue_i(BASE + 32'h804, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    step();

    // Streaming across the bank 0 / bank 1 boundary
    for (int j = 0; j < 16; j++) begin
      issue_d(BASE + 32'h7E0 + 32'(4 * j), 1'b1, 4'hF, 32'hA500_0000 | 32'(j), 32'h0, 1'b0);
      step();
    end
    for (int j = 0; j < 16; j++) begin
      issue_i(BASE + 32'h7E0 + 32'(4 * j), 1'b0, 1'b1, 32'hA500_0000 | 32'(j), 1'b0);
      step();
    end

`ifdef SRAM_ERR_CAPTURE_EN
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("cap_clr_addr", err_addr, 32'h0);
    check("cap_clr_cnt", 32'(err_cnt), 32'd0);
    issue_i(BASE, 1'b1, 1'b1, 32'h0, 1'b1); step();
    issue_d(32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1); step();
    check("cap_addr", err_addr, BASE);
    check("cap_cnt", 32'(err_cnt), 32'd2);
    err_clr = 1'b1;
    issue_d(32'h4, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    step();
    err_clr = 1'b0;
    check("cap_clr_prio_addr", err_addr, 32'h0);
    check("cap_clr_prio_cnt", 32'(err_cnt), 32'd0);
    for (int j = 0; j < 150; j++) begin
      issue_d(32'h10, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      issue_i(32'h20, 1'b0, 1'b1, 32'h0, 1'b1);
      step();
    end
    check("cap_sat_cnt", 32'(err_cnt), 32'd255);
    check("cap_dwins_addr", err_addr, 32'h10);
`endif

    // Drain, then reset with a read in flight: no response may follow
    repeat (4) step();
    d_bus.req = 1'b1; d_bus.addr = BASE + 32'h804; d_bus.be = 4'hF;
    @(posedge clk);
    #1;
    clear_bus();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_d_rvalid", 32'(d_bus.rvalid), 32'd0);
    repeat (4) step();
    check("midrst_d_rvalid_late", 32'(d_bus.rvalid), 32'd0);
    check("d_queue_drained", 32'(d_q.size()), 32'd0);
    check("i_queue_drained", 32'(i_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
